// File: rtl/exu_alu_mc_if.sv
// Request/response bundle between EXU dispatch, the multi-cycle ALU and writeback.
interface exu_alu_mc_if #(
    parameter int XLEN  = 64,
    parameter int TAG_W = 5
);
    logic             alu_req_valid;
    logic             alu_req_ready;
    logic [3:0]       alu_req_op;
    logic             alu_req_word;
    logic [XLEN-1:0]  alu_req_op1;
    logic [XLEN-1:0]  alu_req_op2;
    logic [TAG_W-1:0] alu_req_tag;
    logic             alu_rsp_valid;
    logic             alu_rsp_ready;
    logic [XLEN-1:0]  alu_rsp_res;
    logic [TAG_W-1:0] alu_rsp_tag;
    logic             alu_busy;

    // Requestor / result consumer side.
    modport master (
        output alu_req_valid, alu_req_op, alu_req_word, alu_req_op1, alu_req_op2, alu_req_tag,
        output alu_rsp_ready,
        input  alu_req_ready, alu_rsp_valid, alu_rsp_res, alu_rsp_tag, alu_busy
    );

    // ALU side.
    modport slave (
        input  alu_req_valid, alu_req_op, alu_req_word, alu_req_op1, alu_req_op2, alu_req_tag,
        input  alu_rsp_ready,
        output alu_req_ready, alu_rsp_valid, alu_rsp_res, alu_rsp_tag, alu_busy
    );
endinterface

// File: rtl/exu_alu_mc.sv
// Multi-cycle integer ALU: single-cycle RV ALU ops (incl. RV64 W forms) and an
// iterative shift-add multiplier, with one registered, tagged result slot.
module exu_alu_mc #(
    parameter int XLEN     = 64,
    parameter int WORD_OPS = 1,
    parameter int TAG_W    = 5
) (
    input  logic         clk,
    input  logic         rst,
    exu_alu_mc_if.slave  alu
);
    localparam int SH_W  = $clog2(XLEN);
    localparam int CNT_W = $clog2(XLEN) + 1;
    // W forms only make sense on a 64-bit datapath.
    localparam bit W_EN  = (WORD_OPS != 0) && (XLEN == 64);

    localparam logic [3:0] OP_ADD  = 4'd0,  OP_SUB  = 4'd1,  OP_SLL = 4'd2,  OP_SLT  = 4'd3;
    localparam logic [3:0] OP_SLTU = 4'd4,  OP_XOR  = 4'd5,  OP_SRL = 4'd6,  OP_SRA  = 4'd7;
    localparam logic [3:0] OP_OR   = 4'd8,  OP_AND  = 4'd9,  OP_MUL = 4'd10, OP_PASS2 = 4'd11;

    typedef enum logic {S_IDLE, S_MUL} state_e;

    state_e           state, state_nx;
    logic [XLEN-1:0]  mcand, mplier, acc;
    logic [CNT_W-1:0] cnt, mul_steps;
    logic             mul_word;
    logic [TAG_W-1:0] mul_tag;
    logic             req_ready, busy;
    logic             accept, is_mul, use_w, mul_done;
    logic [XLEN-1:0]  res_c, mul_res;
    logic [31:0]      w32;
    logic [63:0]      w_sx, mul_sx;
    logic             rsp_valid_q;
    logic [XLEN-1:0]  rsp_res_q;
    logic [TAG_W-1:0] rsp_tag_q;

    assign accept    = alu.alu_req_valid && req_ready;
    assign is_mul    = (alu.alu_req_op == OP_MUL);
    assign use_w     = W_EN && alu.alu_req_word &&
                       (alu.alu_req_op inside {OP_ADD, OP_SUB, OP_SLL, OP_SRL, OP_SRA, OP_MUL});
    assign mul_steps = mul_word ? CNT_W'(32) : CNT_W'(XLEN);
    // The cycle after the last step loads the result, hence N+1 edges of latency.
    assign mul_done  = (state == S_MUL) && (cnt == mul_steps);
    assign mul_sx    = {{32{acc[31]}}, acc[31:0]};
    assign mul_res   = mul_word ? mul_sx[XLEN-1:0] : acc;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    // Next-state: enter MUL on a multiply accept, leave once the result is loaded.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (accept && is_mul) state_nx = S_MUL;
            S_MUL:   if (mul_done)         state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // FSM outputs: accept only when idle and the result slot is free or draining.
    always_comb begin
        busy      = (state == S_MUL);
        req_ready = !rst && (state == S_IDLE) && (!rsp_valid_q || alu.alu_rsp_ready);
    end

    // Single-cycle result; W forms work on the low word and sign-extend.
    always_comb begin
        res_c = '0;
        w32   = '0;
        w_sx  = '0;
        if (use_w) begin
            case (alu.alu_req_op)
                OP_ADD:  w32 = alu.alu_req_op1[31:0] + alu.alu_req_op2[31:0];
                OP_SUB:  w32 = alu.alu_req_op1[31:0] - alu.alu_req_op2[31:0];
                OP_SLL:  w32 = alu.alu_req_op1[31:0] << alu.alu_req_op2[4:0];
                OP_SRL:  w32 = alu.alu_req_op1[31:0] >> alu.alu_req_op2[4:0];
                OP_SRA:  w32 = $signed(alu.alu_req_op1[31:0]) >>> alu.alu_req_op2[4:0];
                default: w32 = '0;
            endcase
            w_sx  = {{32{w32[31]}}, w32};
            res_c = w_sx[XLEN-1:0];
        end else begin
            case (alu.alu_req_op)
                OP_ADD:   res_c = alu.alu_req_op1 + alu.alu_req_op2;
                OP_SUB:   res_c = alu.alu_req_op1 - alu.alu_req_op2;
                OP_SLL:   res_c = alu.alu_req_op1 << alu.alu_req_op2[SH_W-1:0];
                OP_SLT:   res_c = {{(XLEN-1){1'b0}}, ($signed(alu.alu_req_op1) < $signed(alu.alu_req_op2))};
                OP_SLTU:  res_c = {{(XLEN-1){1'b0}}, (alu.alu_req_op1 < alu.alu_req_op2)};
                OP_XOR:   res_c = alu.alu_req_op1 ^ alu.alu_req_op2;
                OP_SRL:   res_c = alu.alu_req_op1 >> alu.alu_req_op2[SH_W-1:0];
                OP_SRA:   res_c = $signed(alu.alu_req_op1) >>> alu.alu_req_op2[SH_W-1:0];
                OP_OR:    res_c = alu.alu_req_op1 | alu.alu_req_op2;
                OP_AND:   res_c = alu.alu_req_op1 & alu.alu_req_op2;
                OP_PASS2: res_c = alu.alu_req_op2;
                default:  res_c = '0;
            endcase
        end
    end

    // Shift-add multiplier: latch operands on accept, one partial product per cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand    <= '0;
            mplier   <= '0;
            acc      <= '0;
            cnt      <= '0;
            mul_word <= 1'b0;
            mul_tag  <= '0;
        end else if (accept && is_mul) begin
            mcand    <= alu.alu_req_op1;
            mplier   <= alu.alu_req_op2;
            acc      <= '0;
            cnt      <= '0;
            mul_word <= use_w;
            mul_tag  <= alu.alu_req_tag;
        end else if ((state == S_MUL) && !mul_done) begin
            if (mplier[0]) acc <= acc + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CNT_W'(1);
        end
    end

    // Result slot: load beats drain, so load+drain in one cycle keeps valid high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid_q <= 1'b0;
            rsp_res_q   <= '0;
            rsp_tag_q   <= '0;
        end else if (accept && !is_mul) begin
            rsp_valid_q <= 1'b1;
            rsp_res_q   <= res_c;
            rsp_tag_q   <= alu.alu_req_tag;
        end else if (mul_done) begin
            rsp_valid_q <= 1'b1;
            rsp_res_q   <= mul_res;
            rsp_tag_q   <= mul_tag;
        end else if (rsp_valid_q && alu.alu_rsp_ready) begin
            rsp_valid_q <= 1'b0;
        end
    end

    assign alu.alu_req_ready = req_ready;
    assign alu.alu_busy      = busy;
    assign alu.alu_rsp_valid = rsp_valid_q;
    assign alu.alu_rsp_res   = rsp_res_q;
    assign alu.alu_rsp_tag   = rsp_tag_q;
endmodule

// File: tb/tb_exu_alu_mc.sv
// Directed self-checking bench for exu_alu_mc (XLEN=64, W forms enabled).
module tb_exu_alu_mc;
    localparam int XLEN  = 64;
    localparam int TAG_W = 5;

    localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, SLL = 4'd2, SLT = 4'd3, SLTU = 4'd4;
    localparam logic [3:0] SRL = 4'd6, SRA = 4'd7, AND = 4'd9, MUL = 4'd10, PASS2 = 4'd11;
    localparam logic [3:0] RSV = 4'd13;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    exu_alu_mc_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bus();

    exu_alu_mc #(.XLEN(XLEN), .WORD_OPS(1), .TAG_W(TAG_W)) dut (
        .clk (clk),
        .rst (rst),
        .alu (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] op, input logic word, input logic [63:0] a,
                         input logic [63:0] b, input logic [4:0] tag);
        bus.alu_req_valid = 1'b1;
        bus.alu_req_op    = op;
        bus.alu_req_word  = word;
        bus.alu_req_op1   = a;
        bus.alu_req_op2   = b;
        bus.alu_req_tag   = tag;
    endtask

    // Present a request, wait (bounded) for ready, and return just after the accept edge.
    task automatic issue(input logic [3:0] op, input logic word, input logic [63:0] a,
                         input logic [63:0] b, input logic [4:0] tag);
        int g;
        drive(op, word, a, b, tag);
        g = 0;
        while (bus.alu_req_ready !== 1'b1 && g < 100) begin
            step();
            g++;
        end
        chk("accept_wait", {63'd0, bus.alu_req_ready}, 64'd1);
        step();
        bus.alu_req_valid = 1'b0;
    endtask

    task automatic alu_op(input string name, input logic [3:0] op, input logic word,
                          input logic [63:0] a, input logic [63:0] b, input logic [4:0] tag,
                          input logic [63:0] exp);
        issue(op, word, a, b, tag);
        chk({name, "_valid"}, {63'd0, bus.alu_rsp_valid}, 64'd1);
        chk({name, "_res"}, bus.alu_rsp_res, exp);
        chk({name, "_tag"}, {59'd0, bus.alu_rsp_tag}, {59'd0, tag});
    endtask

    initial begin
        int seen;
        bus.alu_req_valid = 1'b0;
        bus.alu_req_op    = '0;
        bus.alu_req_word  = 1'b0;
        bus.alu_req_op1   = '0;
        bus.alu_req_op2   = '0;
        bus.alu_req_tag   = '0;
        bus.alu_rsp_ready = 1'b1;

        // Reset state
        #1;
        chk("rst_ready", {63'd0, bus.alu_req_ready}, 64'd0);
        chk("rst_valid", {63'd0, bus.alu_rsp_valid}, 64'd0);
        chk("rst_res",   bus.alu_rsp_res, 64'd0);
        chk("rst_tag",   {59'd0, bus.alu_rsp_tag}, 64'd0);
        chk("rst_busy",  {63'd0, bus.alu_busy}, 64'd0);
        step();
        step();
        rst = 1'b0;
        #1;
        chk("post_rst_ready", {63'd0, bus.alu_req_ready}, 64'd1);

        // Single-cycle ops
        alu_op("add",   ADD, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 5'd7, 64'h8000_0000_0000_0000);
        step();
        chk("add_drained", {63'd0, bus.alu_rsp_valid}, 64'd0);
        alu_op("subw",  SUB, 1'b1, 64'd0, 64'd1, 5'd1, 64'hFFFF_FFFF_FFFF_FFFF);
        alu_op("addw",  ADD, 1'b1, 64'h7FFF_FFFF, 64'd1, 5'd2, 64'hFFFF_FFFF_8000_0000);
        alu_op("sra",   SRA, 1'b0, 64'h8000_0000_0000_0000, 64'h43, 5'd3, 64'hF000_0000_0000_0000);
        alu_op("slt",   SLT, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 5'd4, 64'd1);
        alu_op("sltu",  SLTU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 5'd5, 64'd0);
        alu_op("sllw",  SLL, 1'b1, 64'd1, 64'd31, 5'd6, 64'hFFFF_FFFF_8000_0000);
        alu_op("srlw",  SRL, 1'b1, 64'hFFFF_FFFF_8000_0000, 64'd4, 5'd8, 64'h0000_0000_0800_0000);
        alu_op("sraw",  SRA, 1'b1, 64'h8000_0000, 64'd4, 5'd9, 64'hFFFF_FFFF_F800_0000);
        alu_op("sll",   SLL, 1'b0, 64'd1, 64'd63, 5'd10, 64'h8000_0000_0000_0000);
        alu_op("andw",  AND, 1'b1, 64'hFFFF_0000_FFFF_0000, 64'h0F0F_0F0F_0F0F_0F0F, 5'd11,
               64'h0F0F_0000_0F0F_0000);
        alu_op("pass2", PASS2, 1'b0, 64'd5, 64'h1234_5678_9ABC_DEF0, 5'd12, 64'h1234_5678_9ABC_DEF0);
        alu_op("rsvd",  RSV, 1'b0, 64'd5, 64'd6, 5'd13, 64'd0);
        step();

        // 64-bit multiply: result 65 edges after accept, busy and not ready meanwhile
        issue(MUL, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 5'd14);
        for (int j = 0; j < 65; j++) begin
            chk("mul_wait_busy_rdy_vld",
                {61'd0, bus.alu_busy, bus.alu_req_ready, bus.alu_rsp_valid}, 64'b100);
            step();
        end
        chk("mul_valid", {63'd0, bus.alu_rsp_valid}, 64'd1);
        chk("mul_busy",  {63'd0, bus.alu_busy}, 64'd0);
        chk("mul_res",   bus.alu_rsp_res, 64'hFFFF_FFFF_FFFF_FFFD);
        chk("mul_tag",   {59'd0, bus.alu_rsp_tag}, 64'd14);

        // Word multiplies: 33 edges of latency, sign-extended low word
        issue(MUL, 1'b1, 64'h1_0000, 64'h1_0000, 5'd15);
        for (int j = 0; j < 33; j++) begin
            chk("mulw_wait_vld", {63'd0, bus.alu_rsp_valid}, 64'd0);
            step();
        end
        chk("mulw_valid", {63'd0, bus.alu_rsp_valid}, 64'd1);
        chk("mulw_res",   bus.alu_rsp_res, 64'd0);
        chk("mulw_tag",   {59'd0, bus.alu_rsp_tag}, 64'd15);
        issue(MUL, 1'b1, 64'h1_0000, 64'h8000, 5'd16);
        repeat (32) step();
        chk("mulw2_early", {63'd0, bus.alu_rsp_valid}, 64'd0);
        step();
        chk("mulw2_valid", {63'd0, bus.alu_rsp_valid}, 64'd1);
        chk("mulw2_res",   bus.alu_rsp_res, 64'hFFFF_FFFF_8000_0000);
        step();

        // Backpressure: first ADD held, others wait, then drain in order
        bus.alu_rsp_ready = 1'b0;
        issue(ADD, 1'b0, 64'd1, 64'd1, 5'd1);
        drive(ADD, 1'b0, 64'd10, 64'd20, 5'd2);
        for (int j = 0; j < 3; j++) begin
            chk("bp_ready", {63'd0, bus.alu_req_ready}, 64'd0);
            chk("bp_valid", {63'd0, bus.alu_rsp_valid}, 64'd1);
            chk("bp_res",   bus.alu_rsp_res, 64'd2);
            chk("bp_tag",   {59'd0, bus.alu_rsp_tag}, 64'd1);
            step();
        end
        bus.alu_rsp_ready = 1'b1;
        #1;
        chk("bp_ready_up", {63'd0, bus.alu_req_ready}, 64'd1);
        step();
        chk("bp2_valid", {63'd0, bus.alu_rsp_valid}, 64'd1);
        chk("bp2_res",   bus.alu_rsp_res, 64'd30);
        chk("bp2_tag",   {59'd0, bus.alu_rsp_tag}, 64'd2);
        drive(ADD, 1'b0, 64'd100, 64'd5, 5'd3);
        step();
        chk("bp3_valid", {63'd0, bus.alu_rsp_valid}, 64'd1);
        chk("bp3_res",   bus.alu_rsp_res, 64'd105);
        chk("bp3_tag",   {59'd0, bus.alu_rsp_tag}, 64'd3);
        bus.alu_req_valid = 1'b0;
        step();
        chk("bp_drained", {63'd0, bus.alu_rsp_valid}, 64'd0);

        // Reset mid-multiply aborts it with no response
        issue(MUL, 1'b0, 64'd7, 64'd9, 5'd20);
        repeat (10) step();
        chk("abort_busy_before", {63'd0, bus.alu_busy}, 64'd1);
        rst = 1'b1;
        #1;
        chk("abort_valid", {63'd0, bus.alu_rsp_valid}, 64'd0);
        chk("abort_busy",  {63'd0, bus.alu_busy}, 64'd0);
        chk("abort_ready", {63'd0, bus.alu_req_ready}, 64'd0);
        step();
        rst = 1'b0;
        seen = 0;
        for (int j = 0; j < 70; j++) begin
            if (bus.alu_rsp_valid === 1'b1 || bus.alu_busy === 1'b1) seen++;
            step();
        end
        chk("abort_no_rsp", 64'(seen), 64'd0);
        alu_op("add_after", ADD, 1'b0, 64'd2, 64'd3, 5'd21, 64'd5);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
